imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate extender: the next generation of the datapath sign extender. It converts an `IN_W`-bit immediate to `OUT_W` bits in one of four modes: sign, zero, upper/LUI placement, or byte-sign. Results pass through a two-entry skid buffer with valid/ready handshakes on both sides. It sits between decode and the ALU operand mux in the pipelined core, and can stall without losing or duplicating an immediate.

## Interface
Parameters:
- `IN_W`, 16: immediate width; legal range 8 ≤ `IN_W` ≤ `OUT_W`.
- `OUT_W`, 32: extended width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents `in_data`/`in_mode`.
- `in_ready`  out  1  block accepts this cycle; transfer happens when `in_valid & in_ready`.
- `in_data`  in  `IN_W`  raw immediate.
- `in_mode`  in  2  extension mode (encodings in package).
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  downstream accepts; transfer happens when `out_valid & out_ready`.
- `out_data`  out  `OUT_W`  extended result.
- `out_neg`  out  1  MSB of `out_data`, registered alongside it.

## Operation
Modes:
- SIGN (00): replicate `in_data[IN_W-1]` into the upper `OUT_W-IN_W` bits.
- ZERO (01): upper `OUT_W-IN_W` bits are 0.
- UPPER (10): `in_data` occupies bits `[OUT_W-1:OUT_W-IN_W]`; lower bits are 0. This is LUI when `IN_W`=16 and `OUT_W`=32.
- BYTE (11): sign-extend `in_data[7:0]` to `OUT_W`; bits `[IN_W-1:8]` are ignored.
- When `OUT_W` = `IN_W`, SIGN, ZERO and UPPER all pass the data through unchanged.

Extension is computed combinationally at the input. The result is captured into storage, and only registered values drive the outputs.

Storage has two registers: `main` drives the outputs, and `skid` holds one extra entry. The FSM has three states:
- EMPTY: `out_valid`=0, `in_ready`=1. Accept → ONE.
- ONE: `out_valid`=1, `in_ready`=1.
  - Accept without drain → TWO; new word goes to `skid`.
  - Drain without accept → EMPTY.
  - Accept and drain together → ONE; `main` loads the new word.
  - Neither → ONE, hold.
- TWO: `out_valid`=1, `in_ready`=0.
  - Drain → ONE; `skid` moves to `main`.
  - No drain → TWO, hold.
- `in_valid` is ignored in TWO.

Ordering is strict FIFO. No entry is dropped or duplicated.

`out_data` and `out_neg` stay stable while `out_valid & ~out_ready`.

## Timing
Reset (synchronous, checked at `clk` edge):
- State → EMPTY; `out_valid`=0, `out_data`=0, `out_neg`=0, `skid` cleared.
- `in_ready` is forced 0 during any cycle with `reset` high and is 1 in the first cycle after reset deasserts.
- Reset mid-operation discards both entries. A handshake in the reset cycle is not taken.

Latency and throughput:
- Latency is 1 cycle: an input accepted at edge N is visible on `out_data` after edge N.
- Sustained throughput is 1 word/cycle while `out_ready` is held high.
- `in_ready` is a pure function of registered state; there is no combinational path from `out_ready`.
- With `out_ready` low, at most two words are absorbed before `in_ready` drops.

Boundary conditions:
- Full (TWO) plus simultaneous drain: `in_ready` stays 0 that cycle. The freed slot is usable from the next cycle.
- Empty: `out_ready` has no effect.

## Structure
- Package `imm_ext_pkg`:
  - Mode enum `imm_mode_t` (SIGN, ZERO, UPPER, BYTE).
  - FSM state enum `skid_state_t`.
  - Constant `BYTE_W`=8.
- Sub-module `imm_skid_buffer` (parametrised on `DATA_W`) holds the FSM and both registers. It is instantiated with `DATA_W`=`OUT_W`+1 to carry `out_neg`.
- Top level: extension mux plus that instance. Add an elaboration-time check that 8 ≤ `IN_W` ≤ `OUT_W`.

## Test plan
Default `IN_W`=16, `OUT_W`=32 unless stated.
- Modes with `out_ready`=1:
  - 16'h000A SIGN → 32'h0000000A, `out_neg`=0.
  - 16'hFFFA SIGN → 32'hFFFFFFFA, `out_neg`=1.
  - 16'h8000 ZERO → 32'h00008000.
  - 16'h1234 UPPER → 32'h12340000.
  - 16'h00F0 BYTE → 32'hFFFFFFF0.
- Back-pressure:
  - Hold `out_ready`=0 and offer 3 words (0x1, 0x2, 0x3). Only two are accepted; `in_ready` is 0 after the second.
  - Release `out_ready`. Outputs are 0x1, 0x2, 0x3 in order, with no duplicates.
- Streaming: 100 random words and modes, `out_ready`=1, `in_valid`=1. One result per cycle at 1-cycle latency; all match the reference-model extension.
- Random `in_valid`/`out_ready` (50% each), 1000 words: scoreboard order and values; `out_data` stable while stalled.
- Reset while in TWO with entries 0xAAAA and 0x5555 pending:
  - Next cycle: `out_valid`=0, `out_data`=0, `in_ready`=1.
  - Neither pending word ever appears.
- Parameter sweep `IN_W`=8, `OUT_W`=8:
  - 8'h80 SIGN → 8'h80; ZERO → 8'h80; BYTE → 8'h80.
  - 8'h7F UPPER → 8'h7F.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// +------------------------------------------------------------------+
// | imm_ext_pkg : shared types and constants for the immediate        |
// |               extender pipeline.          Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

package imm_ext_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      MODE_SIGN  = 2'b00,
      MODE_ZERO  = 2'b01,
      MODE_UPPER = 2'b10,
      MODE_BYTE  = 2'b11
   } imm_mode_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/imm_skid_buffer.sv
// +------------------------------------------------------------------+
// | imm_skid_buffer : two-entry valid/ready skid buffer, registered   |
// |                   outputs, strict FIFO order.     Rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module imm_skid_buffer
   import imm_ext_pkg::*;
#(
   parameter int DATA_W = 33
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   skid_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              accept;
   logic              drain;

   // Registered ready is masked by reset so no transfer is taken in a reset cycle.
   assign in_ready  = in_ready_q & ~reset;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && !drain) begin
               skid_d  = in_data;
               state_d = ST_TWO;
            end else if (accept && drain) begin
               main_d  = in_data;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_TWO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// +------------------------------------------------------------------+
// | imm_extend_pipe : IN_W -> OUT_W immediate extender (sign, zero,   |
// |                   upper, byte) behind a skid buffer.  Rev 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg
);

   generate
      if (IN_W < BYTE_W || IN_W > OUT_W) begin : g_param_check
         $error("imm_extend_pipe: IN_W must satisfy 8 <= IN_W <= OUT_W");
      end
   endgenerate

   logic [OUT_W-1:0] ext;
   logic [OUT_W:0]   buf_out;

   // Size casts of signed operands sign-extend, and collapse to pass-through when OUT_W == IN_W.
   always_comb begin
      ext = '0;
      case (imm_mode_t'(in_mode))
         MODE_SIGN:  ext = OUT_W'($signed(in_data));
         MODE_ZERO:  ext = OUT_W'(in_data);
         MODE_UPPER: ext = OUT_W'(in_data) << (OUT_W - IN_W);
         MODE_BYTE:  ext = OUT_W'($signed(in_data[BYTE_W-1:0]));
         default:    ext = '0;
      endcase
   end

   imm_skid_buffer #(
      .DATA_W (OUT_W + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ext[OUT_W-1], ext}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign out_neg  = buf_out[OUT_W];
   assign out_data = buf_out[OUT_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// +------------------------------------------------------------------+
// | tb_imm_extend_pipe : scoreboard bench for the immediate extender. |
// |                                             Rev 1.0               |
// +------------------------------------------------------------------+
`default_nettype none

module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  in_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_neg;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  in_data8 = '0;
   logic [1:0]  in_mode8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [7:0]  out_data8;
   logic        out_neg8;

   logic [31:0] drv_exp = '0;
   logic [31:0] sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   bit          rand_rdy = 1'b0;
   bit          stall = 1'b0;
   logic [32:0] held = '0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_data(out_data8), .out_neg(out_neg8)
   );

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext_ref(input logic [15:0] d, input logic [1:0] m);
      case (m)
         2'b00:   return {{16{d[15]}}, d};
         2'b01:   return {16'h0000, d};
         2'b10:   return {d, 16'h0000};
         default: return {{24{d[7]}}, d[7:0]};
      endcase
   endfunction

   // Monitor: push on input handshake, pop/compare on output handshake, check hold while stalled.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         stall = 1'b0;
      end else begin
         if (stall) begin
            check_value("hold_valid", {63'd0, out_valid}, 64'd1);
            check_value("hold_data", {31'd0, out_neg, out_data}, {31'd0, held});
         end
         if (in_valid && in_ready) sb.push_back(drv_exp);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_value("spurious_out", {32'd0, out_data}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
               logic [31:0] e;
               e = sb.pop_front();
               check_value("sb_data", {32'd0, out_data}, {32'd0, e});
               check_value("sb_neg", {63'd0, out_neg}, {63'd0, e[31]});
            end
         end
         stall = out_valid && !out_ready;
         held  = {out_neg, out_data};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_word(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e,
                             output int cycles);
      bit acc;
      cycles   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      drv_exp  = e;
      do begin
         @(negedge clk);
         acc = in_ready;
         step();
         cycles++;
      end while (!acc && cycles < 200);
      if (!acc) check_value("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic directed(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
      int c;
      drive_word(d, m, e, c);
      check_value("lat_valid", {63'd0, out_valid}, 64'd1);
      check_value("lat_data", {32'd0, out_data}, {32'd0, e});
   endtask

   task automatic check8(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e);
      in_valid8 = 1'b1;
      in_data8  = d;
      in_mode8  = m;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      check_value("w8_data", {56'd0, out_data8}, {56'd0, e});
      check_value("w8_neg", {63'd0, out_neg8}, {63'd0, e[7]});
   endtask

   initial begin
      int c;
      int total;
      @(negedge clk);
      check_value("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check_value("rst_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_value("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_value("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_value("post_rst_data", {31'd0, out_neg, out_data}, 64'd0);

      out_ready = 1'b1;
      directed(16'h000A, 2'b00, 32'h0000000A);
      directed(16'hFFFA, 2'b00, 32'hFFFFFFFA);
      directed(16'h8000, 2'b01, 32'h00008000);
      directed(16'h1234, 2'b10, 32'h12340000);
      directed(16'h00F0, 2'b11, 32'hFFFFFFF0);
      step();

      // Back-pressure: two words absorbed, third blocked until a slot frees.
      out_ready = 1'b0;
      drive_word(16'h0001, 2'b01, 32'h1, c);
      drive_word(16'h0002, 2'b01, 32'h2, c);
      in_valid = 1'b1;
      in_data  = 16'h0003;
      in_mode  = 2'b01;
      drv_exp  = 32'h3;
      @(negedge clk);
      check_value("full_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      #1;
      check_value("full_drain_in_ready", {63'd0, in_ready}, 64'd0);
      drive_word(16'h0003, 2'b01, 32'h3, c);
      repeat (4) step();
      check_value("bp_empty", {32'd0, 32'(sb.size())}, 64'd0);

      // Streaming: one word per cycle.
      total = 0;
      for (int i = 0; i < 100; i++) begin
         logic [15:0] d;
         logic [1:0]  m;
         d = 16'($urandom);
         m = 2'($urandom_range(0, 3));
         drive_word(d, m, ext_ref(d, m), c);
         total += c;
      end
      check_value("stream_cycles", 64'(total), 64'd100);
      repeat (3) step();

      // Random valid/ready.
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] d;
         logic [1:0]  m;
         while ($urandom_range(0, 1) == 0) step();
         d = 16'($urandom);
         m = 2'($urandom_range(0, 3));
         drive_word(d, m, ext_ref(d, m), c);
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      c = 0;
      while (sb.size() != 0 && c < 50) begin
         step();
         c++;
      end
      check_value("rand_drained", {32'd0, 32'(sb.size())}, 64'd0);

      // Reset while holding two entries.
      out_ready = 1'b0;
      drive_word(16'hAAAA, 2'b01, 32'h0000AAAA, c);
      drive_word(16'h5555, 2'b01, 32'h00005555, c);
      reset = 1'b1;
      @(negedge clk);
      check_value("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_value("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_value("mid_rst_data", {32'd0, out_data}, 64'd0);
      check_value("mid_rst_in_ready2", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (5) step();

      // Equal-width instance.
      check8(8'h80, 2'b00, 8'h80);
      check8(8'h80, 2'b01, 8'h80);
      check8(8'h80, 2'b11, 8'h80);
      check8(8'h7F, 2'b10, 8'h7F);
      check8(8'h05, 2'b11, 8'h05);

      check_value("final_empty", {32'd0, 32'(sb.size())}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
